vga_stream_probe: RTL and testbench

- Reads back what the overlay chain has drawn. The block taps the 26-bit RGB stream and samples NBITS pixels along one row, starting at (x_pos, y_pos) with stride 1<<zoom.
- It packs the samples into a word and hands it out once per frame on a valid/ready port.
- It sits at the end of an overlay chain (e.g. after the hex-register overlay) for on-chip self-check. The stream is forwarded with one cycle of latency.

---
 rtl/vga_stream_probe.sv | 219 +++++++++++++++++++++
 tb/tb_vga_stream_probe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_probe.sv
// vga_stream_probe
// ----------------------------------------------------------------------------
// Purpose: on-chip read-back of an overlay chain's output. The block taps the
// 26-bit RGB pixel stream and samples NBITS pixels along one row, starting at
// (x_pos, y_pos) with a stride of 1<<zoom. The samples are packed into a word,
// first sample in the MSB. At most one word per frame is offered on a
// valid/ready port. The stream itself is forwarded with one cycle of latency.
//
// Optional build macro: VGA_PROBE_MARK_EN
//   defined   : pixels that are sampled leave the block painted red (RGB=3'b001)
//   undefined : strRGB_o is a pure one-cycle copy of strRGB_i
//
// Ports:
//   px_clk     in   pixel clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   strRGB_i   in   [0] active, [1] VS, [2] HS, [12:3] YC, [22:13] XC,
//                   [25:23] RGB (bit23 R, bit24 G, bit25 B)
//   zoom       in   stride exponent (stride = 1<<zoom)
//   x_pos      in   X of the first sample
//   y_pos      in   row that is sampled
//   strRGB_o   out  strRGB_i delayed by one px_clk
//   data_o     out  captured word, first sample in the MSB
//   valid_o    out  data_o holds an unconsumed word
//   ready_i    in   consumer accepts data_o
//   overrun_o  out  sticky: a word was replaced before it was consumed
//
// States:
//   WAIT_VS | idle until the next VS rising edge
//   ARMED   | coordinates latched, waiting for the first sample pixel
//   SAMPLE  | collecting samples along the row
//   DONE    | one cycle: hand the completed word to the output register
// ----------------------------------------------------------------------------
module vga_stream_probe #(
  parameter int         NBITS    = 16,
  parameter logic [2:0] RGB_MASK = 3'b111
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic [25:0]      strRGB_i,
  input  logic [2:0]       zoom,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  output logic [25:0]      strRGB_o,
  output logic [NBITS-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [NBITS-1:0] MSB_ONE = (NBITS)'(1) << (NBITS - 1);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARMED   = 2'd1,
    SAMPLE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // stream fields
  logic       px_active;
  logic       px_vs;
  logic [9:0] px_yc;
  logic [9:0] px_xc;
  logic [2:0] px_rgb;

  assign px_active = strRGB_i[0];
  assign px_vs     = strRGB_i[1];
  assign px_yc     = strRGB_i[12:3];
  assign px_xc     = strRGB_i[22:13];
  assign px_rgb    = strRGB_i[25:23];

  // capture datapath
  logic             vs_q;
  logic [9:0]       y_pos_r;
  logic [2:0]       zoom_r;
  logic [10:0]      next_x_q;
  logic [CW-1:0]    cnt_q;
  logic [NBITS-1:0] shift_q;

  logic frame_start;
  logic row_ok;
  logic hit;
  logic last_hit;
  logic sample_bit;
  logic [10:0] stride;

  assign frame_start = px_vs & ~vs_q;
  assign row_ok      = px_active & (px_yc == y_pos_r);
  // next_x_q[10] set means the stride walked off the 10-bit X range; the
  // 11-bit compare then can never match.
  assign hit         = row_ok & ({1'b0, px_xc} == next_x_q);
  assign last_hit    = hit & (cnt_q == CW'(NBITS - 1));
  assign sample_bit  = |(px_rgb & RGB_MASK);
  assign stride      = 11'd1 << zoom_r;

  // FSM control outputs
  logic arm;
  logic take;
  logic load;

  // ---------------- state register ----------------
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_VS;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  // A VS rising edge always restarts the capture with fresh coordinates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: begin
        if (frame_start) state_d = ARMED;
      end
      ARMED: begin
        if (frame_start)   state_d = ARMED;
        else if (last_hit) state_d = DONE;
        else if (hit)      state_d = SAMPLE;
      end
      SAMPLE: begin
        if (frame_start)                   state_d = ARMED;
        else if (last_hit)                 state_d = DONE;
        else if (hit)                      state_d = SAMPLE;
        else if (!row_ok || next_x_q[10])  state_d = WAIT_VS;
      end
      DONE: begin
        if (frame_start) state_d = ARMED;
        else             state_d = WAIT_VS;
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    arm  = frame_start;
    take = 1'b0;
    load = 1'b0;
    case (state_q)
      ARMED, SAMPLE: take = hit & ~frame_start;
      DONE:          load = 1'b1;
      default: ;
    endcase
  end

  // ---------------- capture datapath ----------------
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      y_pos_r  <= '0;
      zoom_r   <= '0;
      next_x_q <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
    end else begin
      vs_q <= px_vs;
      if (arm) begin
        y_pos_r  <= y_pos;
        zoom_r   <= zoom;
        next_x_q <= {1'b0, x_pos};
        cnt_q    <= '0;
        shift_q  <= '0;
      end else if (take) begin
        // sample number cnt_q lands in bit NBITS-1-cnt_q
        if (sample_bit) shift_q <= shift_q | (MSB_ONE >> cnt_q);
        cnt_q    <= cnt_q + CW'(1);
        next_x_q <= next_x_q + stride;
      end
    end
  end

  // ---------------- output handshake ----------------
  logic xfer;
  assign xfer = valid_o & ready_i;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (load) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (xfer) begin
        valid_o <= 1'b0;
      end

      // a load that replaces an unconsumed word sets the flag; a transfer
      // that is not itself an overrun clears it
      if (load && valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end else if (xfer) begin
        overrun_o <= 1'b0;
      end
    end
  end

  // ---------------- stream forwarding ----------------
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      strRGB_o <= '0;
    end else begin
`ifdef VGA_PROBE_MARK_EN
      if (take) strRGB_o <= {3'b001, strRGB_i[22:0]};
      else      strRGB_o <= strRGB_i;
`else
      strRGB_o <= strRGB_i;
`endif
    end
  end

endmodule

// File: tb/tb_vga_stream_probe.sv
// Self-checking bench for vga_stream_probe. Frames are compressed: VS pulse,
// the row above the sampled row, then the sampled row (800 pixels each).
module tb_vga_stream_probe;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic [25:0] strRGB_i;
  logic [2:0]  zoom;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [25:0] strRGB_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;
  int mon_fail_prints = 0;

  bit lit    [0:1023];
  bit mark_x [0:1023];
  logic [9:0] mark_row = '0;

  vga_stream_probe #(.NBITS(16), .RGB_MASK(3'b111)) dut (
    .px_clk    (px_clk),
    .rst_n     (rst_n),
    .strRGB_i  (strRGB_i),
    .zoom      (zoom),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .strRGB_o  (strRGB_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 px_clk = ~px_clk;

  // stream path monitor: output must equal the input seen at the previous edge
  logic [25:0] in_at_edge;
  logic        mon_ok;

  always @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_ok <= 1'b0;
    end else begin
      mon_ok     <= 1'b1;
      in_at_edge <= strRGB_i;
    end
  end

  always @(negedge px_clk) begin
    logic [25:0] exp_o;
    if (mon_ok && rst_n) begin
      exp_o = in_at_edge;
`ifdef VGA_PROBE_MARK_EN
      if (exp_o[0] && exp_o[12:3] == mark_row && mark_x[exp_o[22:13]])
        exp_o[25:23] = 3'b001;
`endif
      checks++;
      if (strRGB_o !== exp_o) begin
        errors++;
        if (mon_fail_prints < 10)
          $display("FAIL stream_delay: got %h expected %h", strRGB_o, exp_o);
        mon_fail_prints++;
      end
    end
  end

  task automatic drive(input logic act, input logic vs, input logic [9:0] yc,
                       input logic [9:0] xc, input logic [2:0] rgb, input logic rdy);
    @(posedge px_clk);
    #1;
    strRGB_i = {rgb, xc, yc, 1'b0, vs, act};
    ready_i  = rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'd0, 10'd0, 3'b000, 1'b0);
  endtask

  // coordinates + expected sample positions (for the marker check)
  task automatic setup(input int x, input int y, input int z);
    x_pos    = 10'(x);
    y_pos    = 10'(y);
    zoom     = 3'(z);
    mark_row = 10'(y);
    for (int i = 0; i < 1024; i++) mark_x[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int p;
      p = x + (i << z);
      if (p < 800) mark_x[p] = 1'b1;
    end
  endtask

  task automatic set_word(input int x0, input int z, input logic [15:0] w);
    for (int i = 0; i < 1024; i++) lit[i] = 1'b0;
    for (int i = 0; i < 16; i++)
      if (w[15-i]) lit[x0 + (i << z)] = 1'b1;
  endtask

  // stop_x: last pixel of the sampled row to drive (-1 = full row)
  // rdy_x : pixel of the sampled row during which ready_i is 1 (-1 = none)
  task automatic run_frame(input int row, input int stop_x, input int rdy_x);
    drive(1'b0, 1'b1, 10'd0, 10'd0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 10'd0, 10'd0, 3'b000, 1'b0);
    idle(2);
    for (int x = 0; x < 800; x++)
      drive(1'b1, 1'b0, 10'(row - 1), 10'(x), 3'(1 << (x % 3)), 1'b0);
    idle(4);
    for (int x = 0; x < 800; x++) begin
      if (stop_x >= 0 && x > stop_x) break;
      drive(1'b1, 1'b0, 10'(row), 10'(x),
            lit[x] ? 3'(1 << (x % 3)) : 3'b000, x == rdy_x);
    end
    if (stop_x < 0) idle(8);
  endtask

  task automatic consume(input string name);
    drive(1'b0, 1'b0, 10'd0, 10'd0, 3'b000, 1'b1);
    idle(1);
    @(negedge px_clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume_valid: got %b expected 0", name, valid_o);
    end
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume_overrun: got %b expected 0", name, overrun_o);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] w,
                            input logic v, input logic ov);
    @(negedge px_clk);
    checks++;
    if (data_o !== w) begin
      errors++;
      $display("FAIL %s_data: got %h expected %h", name, data_o, w);
    end
    checks++;
    if (valid_o !== v) begin
      errors++;
      $display("FAIL %s_valid: got %b expected %b", name, valid_o, v);
    end
    checks++;
    if (overrun_o !== ov) begin
      errors++;
      $display("FAIL %s_overrun: got %b expected %b", name, overrun_o, ov);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (strRGB_o !== 26'd0) begin
      errors++;
      $display("FAIL %s_stream: got %h expected 0", name, strRGB_o);
    end
    checks++;
    if (data_o !== 16'd0) begin
      errors++;
      $display("FAIL %s_data: got %h expected 0", name, data_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b expected 0", name, valid_o);
    end
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_overrun: got %b expected 0", name, overrun_o);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    strRGB_i = 26'h3FF_FFFF;
    ready_i  = 1'b0;
    setup(0, 0, 0);
    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    check_zero("reset");
    #1;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic();
    setup(100, 50, 0);
    set_word(100, 0, 16'hAAAA);
    run_frame(50, -1, -1);
    check_word("basic", 16'hAAAA, 1'b1, 1'b0);
    consume("basic");
  endtask

  task automatic test_stride();
    setup(8, 50, 3);
    set_word(8, 3, 16'h8001);
    lit[9] = 1'b1; lit[12] = 1'b1; lit[20] = 1'b1; lit[100] = 1'b1;
    run_frame(50, -1, -1);
    check_word("stride", 16'h8001, 1'b1, 1'b0);
    consume("stride");
  endtask

  task automatic test_overrun();
    setup(100, 50, 0);
    set_word(100, 0, 16'h1234);
    run_frame(50, -1, -1);
    check_word("overrun_first", 16'h1234, 1'b1, 1'b0);
    set_word(100, 0, 16'h5678);
    run_frame(50, -1, -1);
    check_word("overrun_second", 16'h5678, 1'b1, 1'b1);
    consume("overrun");
  endtask

  // last sample at XC=115 -> DONE during XC=116 -> load coincides with ready
  task automatic test_back_to_back();
    setup(100, 50, 0);
    set_word(100, 0, 16'h0F0F);
    run_frame(50, -1, -1);
    set_word(100, 0, 16'hF00D);
    run_frame(50, -1, 116);
    check_word("load_xfer", 16'hF00D, 1'b1, 1'b0);
    consume("load_xfer");
  endtask

  task automatic test_abort();
    setup(790, 50, 0);
    for (int i = 0; i < 1024; i++) lit[i] = 1'b1;
    run_frame(50, -1, -1);
    @(negedge px_clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid: got %b expected 0", valid_o);
    end
    setup(10, 50, 0);
    set_word(10, 0, 16'hC000);
    run_frame(50, -1, -1);
    check_word("after_abort", 16'hC000, 1'b1, 1'b0);
  endtask

  // enters with C000 pending; a second word makes overrun set before reset
  task automatic test_reset_mid();
    setup(100, 50, 0);
    set_word(100, 0, 16'hAAAA);
    run_frame(50, -1, -1);
    check_word("pre_reset", 16'hAAAA, 1'b1, 1'b1);
    set_word(100, 0, 16'hFFFF);
    run_frame(50, 105, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    run_frame(50, -1, -1);
    check_word("post_reset", 16'hFFFF, 1'b1, 1'b0);
    consume("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
